alu_reg_sequencer: RTL and testbench

//  Command-driven front/back end for the 32-bit combinational ALU.
//  - Accepts one register-to-register command, reads operands from a

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_regfile.sv | 40 ++++
 rtl/alu_reg_sequencer.sv | 127 ++++++++++++
 tb/tb_alu_reg_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU register sequencer: opcode map,
// FSM state encoding and a small opcode helper.
package alu_pkg;

    // ALU opcode map (4-bit)
    localparam logic [3:0] OP_ZERO   = 4'h0;
    localparam logic [3:0] OP_PASS_A = 4'h1;
    localparam logic [3:0] OP_PASS_B = 4'h2;
    localparam logic [3:0] OP_NOT_A  = 4'h3;
    localparam logic [3:0] OP_INC_A  = 4'h4;
    localparam logic [3:0] OP_DEC_A  = 4'h5;
    localparam logic [3:0] OP_RSVD   = 4'h6;
    localparam logic [3:0] OP_ADD    = 4'h7;
    localparam logic [3:0] OP_SUB    = 4'h8;
    localparam logic [3:0] OP_AND    = 4'h9;
    localparam logic [3:0] OP_OR     = 4'hA;
    localparam logic [3:0] OP_XOR    = 4'hB;
    localparam logic [3:0] OP_SHL    = 4'hC;
    localparam logic [3:0] OP_SHR    = 4'hD;
    localparam logic [3:0] OP_SLTU   = 4'hE;
    localparam logic [3:0] OP_PARITY = 4'hF;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    // The reserved opcode leaves the ALU output undefined
    function automatic logic is_rsvd(input logic [3:0] op);
        return (op == OP_RSVD);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREG x DATA_W register file: two asynchronous read ports, one
// synchronous write port, index 0 hardwired to zero, cleared on reset.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = 8,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] i_ra,
    input  logic [REG_AW-1:0] i_rb,
    output logic [DATA_W-1:0] o_rd_a,
    output logic [DATA_W-1:0] o_rd_b,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_wa,
    input  logic [DATA_W-1:0] i_wd
);

    logic [DATA_W-1:0] r_mem [NREG];

    // Storage: clear everything on reset, never write index 0
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_wa != '0)) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    // Read ports: index 0 always returns zero
    always_comb begin
        o_rd_a = (i_ra == '0) ? '0 : r_mem[i_ra];
        o_rd_b = (i_rb == '0) ? '0 : r_mem[i_rb];
    end

endmodule

// File: rtl/alu_reg_sequencer.sv
// Command front/back end for the combinational ALU. Reads operands from
// the local register file, drives registered A/B/opcode to the ALU, one
// cycle later captures the ALU output, writes it back and presents it on
// the result port.
//
// Handshake: a transfer happens on a rising edge where valid and ready
// are both high. cmd_* is accepted only in IDLE (cmd_ready=1); a producer
// holds cmd_valid and its payload until then. res_valid, once high, holds
// res_data/res_rd/res_err stable until the edge where res_ready is high.
module alu_reg_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = 8,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [REG_AW-1:0] cmd_rd,
    input  logic [REG_AW-1:0] cmd_ra,
    input  logic [REG_AW-1:0] cmd_rb,
    input  logic              cmd_imm_sel,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [REG_AW-1:0] res_rd,
    output logic              res_err,
    output logic [1:0]        dbg_state
);

    state_t            r_state;
    state_t            w_next_state;
    logic [REG_AW-1:0] r_rd;
    logic [DATA_W-1:0] w_reg_a;
    logic [DATA_W-1:0] w_reg_b;
    logic              w_accept;
    logic              w_capture;
    logic              w_res_done;
    logic              w_rsvd;
    logic              w_we;

    alu_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .i_ra   (cmd_ra),
        .i_rb   (cmd_rb),
        .o_rd_a (w_reg_a),
        .o_rd_b (w_reg_b),
        .i_we   (w_we),
        .i_wa   (r_rd),
        .i_wd   (alu_out)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: fixed IDLE -> ISSUE -> CAPTURE -> RESP ring
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (cmd_valid) w_next_state = S_ISSUE;
            S_ISSUE:   w_next_state = S_CAPTURE;
            S_CAPTURE: w_next_state = S_RESP;
            S_RESP:    if (res_ready) w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // State-decoded controls; write-back is suppressed for the reserved opcode
    always_comb begin
        cmd_ready  = (r_state == S_IDLE);
        w_accept   = cmd_valid && cmd_ready;
        w_capture  = (r_state == S_CAPTURE);
        w_res_done = (r_state == S_RESP) && res_ready;
        w_rsvd     = is_rsvd(alu_opcode);
        w_we       = w_capture && !w_rsvd;
        dbg_state  = r_state;
    end

    // Operand launch on accept, result capture one cycle after issue
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            r_rd       <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_rd     <= '0;
            res_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                alu_a      <= w_reg_a;
                alu_b      <= cmd_imm_sel ? cmd_imm : w_reg_b;
                alu_opcode <= cmd_op;
                r_rd       <= cmd_rd;
            end
            if (w_capture) begin
                res_data  <= w_rsvd ? '0 : alu_out;
                res_rd    <= r_rd;
                res_err   <= w_rsvd;
                res_valid <= 1'b1;
            end else if (w_res_done) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_reg_sequencer.sv
// Bench for alu_reg_sequencer with a behavioural ALU attached. Expected
// results come from a command-level model (register array + ALU function)
// and are queued at accept time; a negedge monitor pops on every result
// handshake and compares.
module tb_alu_reg_sequencer;
    import alu_pkg::*;

    localparam int DATA_W = 32;
    localparam int NREG   = 8;
    localparam int REG_AW = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [3:0]        cmd_op = '0;
    logic [REG_AW-1:0] cmd_rd = '0;
    logic [REG_AW-1:0] cmd_ra = '0;
    logic [REG_AW-1:0] cmd_rb = '0;
    logic              cmd_imm_sel = 1'b0;
    logic [DATA_W-1:0] cmd_imm = '0;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [3:0]        alu_opcode;
    logic [DATA_W-1:0] alu_out;
    logic              res_valid;
    logic              res_ready = 1'b1;
    logic [DATA_W-1:0] res_data;
    logic [REG_AW-1:0] res_rd;
    logic              res_err;
    logic [1:0]        dbg_state;

    alu_reg_sequencer #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .REG_AW (REG_AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_rd      (cmd_rd),
        .cmd_ra      (cmd_ra),
        .cmd_rb      (cmd_rb),
        .cmd_imm_sel (cmd_imm_sel),
        .cmd_imm     (cmd_imm),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_opcode  (alu_opcode),
        .alu_out     (alu_out),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_rd      (res_rd),
        .res_err     (res_err),
        .dbg_state   (dbg_state)
    );

    // ---------------- ALU behaviour ----------------
    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            OP_ZERO:   return 32'h0;
            OP_PASS_A: return a;
            OP_PASS_B: return b;
            OP_NOT_A:  return ~a;
            OP_INC_A:  return a + 32'd1;
            OP_DEC_A:  return a - 32'd1;
            OP_ADD:    return a + b;
            OP_SUB:    return a - b;
            OP_AND:    return a & b;
            OP_OR:     return a | b;
            OP_XOR:    return a ^ b;
            OP_SHL:    return a << b[4:0];
            OP_SHR:    return a >> b[4:0];
            OP_SLTU:   return {31'h0, (a < b)};
            OP_PARITY: return {31'h0, ^a};
            default:   return 32'hDEADBEEF; // reserved: garbage on purpose
        endcase
    endfunction

    always_comb alu_out = alu_f(alu_opcode, alu_a, alu_b);

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [DATA_W+REG_AW:0] exp_q[$];   // {err, rd, data}
    int                     acc_q[$];   // accept cycle per queued command
    logic [31:0]            ref_regs [NREG];
    int                     checks = 0;
    int                     failures = 0;
    logic [31:0]            last_data = '0;
    logic [2:0]             last_rd = '0;
    logic                   last_err = 1'b0;
    logic                   prev_valid = 1'b0;
    logic                   rand_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [DATA_W+REG_AW:0] e;
        if (!rst) begin
            if (res_valid && !prev_valid) begin
                if (acc_q.size() > 0) check("latency", 64'(cyc - acc_q[0]), 64'd3);
                else check("spurious_valid", 64'(res_valid), 64'd0);
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 64'(res_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    void'(acc_q.pop_front());
                    check("res_data", 64'(res_data), 64'(e[31:0]));
                    check("res_rd", 64'(res_rd), 64'(e[34:32]));
                    check("res_err", 64'(res_err), 64'(e[35]));
                    last_data = res_data;
                    last_rd   = res_rd;
                    last_err  = res_err;
                end
            end
        end
        prev_valid = res_valid;
    end

    // Random back-pressure on the result port
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) res_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_model();
        for (int i = 0; i < NREG; i++) ref_regs[i] = '0;
        exp_q.delete();
        acc_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
    endtask

    // Issue one command, wait (bounded) for acceptance, queue its expected result
    task automatic send_cmd(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra,
                            input logic [2:0] rb, input logic imm_sel, input logic [31:0] imm);
        int n = 0;
        logic ok = 1'b0;
        logic [31:0] a, b, r;
        logic e;
        @(posedge clk);
        #1;
        cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb;
        cmd_imm_sel = imm_sel; cmd_imm = imm; cmd_valid = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (cmd_ready) ok = 1'b1;
            else n++;
        end
        if (!ok) begin
            check("accept_timeout", 64'(cmd_ready), 64'd1);
            cmd_valid = 1'b0;
            return;
        end
        a = ref_regs[ra];
        b = imm_sel ? imm : ref_regs[rb];
        if (op == OP_RSVD) begin
            r = 32'h0;
            e = 1'b1;
        end else begin
            r = alu_f(op, a, b);
            e = 1'b0;
            if (rd != 3'd0) ref_regs[rd] = r;
        end
        exp_q.push_back({e, rd, r});
        acc_q.push_back(cyc);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op = 4'($urandom);
        cmd_imm = $urandom;
    endtask

    // Wait (bounded) until every queued result has been returned
    task automatic collect();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("result_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
            acc_q.delete();
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0] hold_data;
        int n;

        clear_model();
        do_reset();

        // Reset state
        @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_data", 64'(res_data), 64'd0);
        check("rst_res_rd", 64'(res_rd), 64'd0);
        check("rst_res_err", 64'(res_err), 64'd0);
        check("rst_alu_a", 64'(alu_a), 64'd0);
        check("rst_alu_b", 64'(alu_b), 64'd0);
        check("rst_alu_opcode", 64'(alu_opcode), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(S_IDLE));

        // 1: increment of r0 into r1
        send_cmd(OP_INC_A, 3'd1, 3'd0, 3'd0, 1'b1, $urandom);
        collect();
        check("t1_data", 64'(last_data), 64'd1);
        check("t1_rd", 64'(last_rd), 64'd1);

        // 2: add and subtract of loaded registers
        send_cmd(OP_PASS_B, 3'd1, 3'd0, 3'd0, 1'b1, 32'd5);
        send_cmd(OP_PASS_B, 3'd2, 3'd0, 3'd0, 1'b1, 32'd3);
        send_cmd(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 32'd0);
        collect();
        check("t2_add", 64'(last_data), 64'd8);
        send_cmd(OP_SUB, 3'd4, 3'd2, 3'd1, 1'b0, 32'd0);
        collect();
        check("t2_sub", 64'(last_data), 64'hFFFFFFFE);

        // 3: dependent chain, each command reads the previous write-back
        send_cmd(OP_PASS_B, 3'd1, 3'd0, 3'd0, 1'b1, 32'd0);
        for (int i = 0; i < 4; i++) send_cmd(OP_INC_A, 3'd1, 3'd1, 3'd0, 1'b0, 32'd0);
        collect();
        check("t3_chain", 64'(last_data), 64'd4);

        // 4: reserved opcode, then writes to r0
        send_cmd(OP_RSVD, 3'd3, 3'd1, 3'd2, 1'b0, 32'd0);
        collect();
        check("t4_rsvd_err", 64'(last_err), 64'd1);
        check("t4_rsvd_data", 64'(last_data), 64'd0);
        send_cmd(OP_PASS_A, 3'd5, 3'd3, 3'd0, 1'b0, 32'd0);
        collect();
        check("t4_r3_kept", 64'(last_data), 64'd8);
        send_cmd(OP_PASS_A, 3'd0, 3'd3, 3'd0, 1'b0, 32'd0);
        send_cmd(OP_PASS_A, 3'd6, 3'd0, 3'd0, 1'b0, 32'd0);
        collect();
        check("t4_r0_zero", 64'(last_data), 64'd0);

        // 5: result back-pressure
        res_ready = 1'b0;
        send_cmd(OP_ADD, 3'd7, 3'd1, 3'd2, 1'b0, 32'd0);
        n = 0;
        while (!res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t5_valid_seen", 64'(res_valid), 64'd1);
        hold_data = res_data;
        check("t5_first_data", 64'(hold_data), 64'd7);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t5_hold_valid", 64'(res_valid), 64'd1);
            check("t5_hold_data", 64'(res_data), 64'(hold_data));
            check("t5_hold_cmd_ready", 64'(cmd_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t5_idle_after", 64'(cmd_ready), 64'd1);
        check("t5_valid_drop", 64'(res_valid), 64'd0);
        collect();

        // 6a: reset while a command is in ISSUE
        send_cmd(OP_PASS_B, 3'd1, 3'd0, 3'd0, 1'b1, 32'h1234);
        collect();
        @(posedge clk);
        #1;
        cmd_op = OP_INC_A; cmd_rd = 3'd2; cmd_ra = 3'd1; cmd_imm_sel = 1'b0; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("t6_in_issue", 64'(dbg_state), 64'(S_ISSUE));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
        @(negedge clk);
        check("t6a_valid", 64'(res_valid), 64'd0);
        check("t6a_state", 64'(dbg_state), 64'(S_IDLE));

        // 6b: reset exactly at the CAPTURE edge
        send_cmd(OP_PASS_B, 3'd1, 3'd0, 3'd0, 1'b1, 32'h55AA);
        collect();
        @(posedge clk);
        #1;
        cmd_op = OP_INC_A; cmd_rd = 3'd2; cmd_ra = 3'd1; cmd_imm_sel = 1'b0; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        check("t6_in_capture", 64'(dbg_state), 64'(S_CAPTURE));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
        @(negedge clk);
        check("t6b_valid", 64'(res_valid), 64'd0);
        check("t6b_data", 64'(res_data), 64'd0);
        for (int i = 0; i < NREG; i++) send_cmd(OP_PASS_A, 3'd0, 3'(i), 3'd0, 1'b0, 32'd0);
        collect();

        // Randomized commands with random result back-pressure
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            send_cmd(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                     3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), $urandom);
        end
        collect();
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
